// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset defaults and helpers for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Clear the byte offset so every bus request is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
//   req   : request valid
//   addr  : word address of the request
//   gnt   : request accepted this cycle
//   rvld  : in-order response valid (at least one cycle after its grant)
//   rdata : response instruction word
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvld;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvld, rdata);
  modport slave  (input req, addr, output gnt, rvld, rdata);

endinterface

// File: rtl/ifu_fetch_queue.sv
// In-order fetch queue: circular buffer of {addr, data} with head/tail/fill pointers.
// An entry is allocated at grant time and filled later by its response.
//   clear_i        : invalidate every entry (wins over alloc/fill/pop)
//   alloc_i/_addr_i: append an unfilled entry at the tail
//   fill_i/_data_i : write the oldest unfilled entry
//   pop_i          : retire the head entry
//   head_*_o       : head entry state and contents
//   alloc_cnt_o    : entries allocated, filled or not
//   unfilled_cnt_o : entries allocated but still waiting for data
module ifu_fetch_queue
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    alloc_i,
  input  logic [XLEN-1:0]         alloc_addr_i,
  input  logic                    fill_i,
  input  logic [ILEN-1:0]         fill_data_i,
  input  logic                    pop_i,
  output logic                    head_filled_o,
  output logic [XLEN-1:0]         head_addr_o,
  output logic [ILEN-1:0]         head_data_o,
  output logic [$clog2(Depth):0]  alloc_cnt_o,
  output logic [$clog2(Depth):0]  unfilled_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]   head_q, tail_q, fill_q;
  logic [XLEN-1:0] addr_q [Depth];
  logic [ILEN-1:0] data_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      if (alloc_i) begin
        addr_q[tail_q[PtrW-1:0]] <= alloc_addr_i;
        tail_q                   <= tail_q + 1'b1;
      end
      if (fill_i) begin
        data_q[fill_q[PtrW-1:0]] <= fill_data_i;
        fill_q                   <= fill_q + 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + 1'b1;
      end
    end
  end

  // fill_q never passes tail_q and head_q never passes fill_q.
  assign head_filled_o  = (head_q != fill_q);
  assign head_addr_o    = addr_q[head_q[PtrW-1:0]];
  assign head_data_o    = data_q[head_q[PtrW-1:0]];
  assign alloc_cnt_o    = tail_q - head_q;
  assign unfilled_cnt_o = tail_q - fill_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests on the
// instruction bus and hands returned instructions to the BPU in program order.
//   i_clk/i_rstn               : clock, asynchronous active-low reset
//   i_flush/i_flush_addr       : EXU redirect (highest priority)
//   i_bpu_taken/i_bpu_jaddr    : BPU predicted-taken redirect
//   i_wait                     : BPU stall, hold the current output
//   ibus                       : instruction bus master
//   o_data_vld/o_iaddr/o_data  : instruction and its PC towards the BPU
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_addr,
  input  logic            i_bpu_taken,
  input  logic [XLEN-1:0] i_bpu_jaddr,
  input  logic            i_wait,
  ifu_fetch_if.master     ibus,
  output logic            o_data_vld,
  output logic [XLEN-1:0] o_iaddr,
  output logic [ILEN-1:0] o_data
);

  localparam int unsigned     CntW    = $clog2(QDEPTH) + 1;
  localparam logic [CntW:0]   QDepthW = (CntW + 1)'(QDEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] alloc_cnt, unfilled_cnt;
  logic [CntW:0]   credit_sum;
  logic            redirect, grant, discard, undiscard, fill, pop, head_filled;

  assign redirect   = i_flush | i_bpu_taken;
  assign credit_sum = {1'b0, alloc_cnt} + {1'b0, drop_q};

  // Responses still owed to dropped requests hold credit until they return, so
  // queue slots plus stale responses never exceed QDEPTH. Gated by reset so the
  // bus stays idle while reset is held.
  assign ibus.req  = i_rstn & (credit_sum < QDepthW) & ~redirect;
  assign ibus.addr = word_align(pc_q);
  assign grant     = ibus.req & ibus.gnt;

  assign discard   = ibus.rvld & (drop_q != '0);
  assign undiscard = ibus.rvld & ~discard;
  // A live response in a redirect cycle belongs to an entry being invalidated.
  assign fill      = undiscard & ~redirect;

  assign o_data_vld = head_filled & ~i_flush;
  assign pop        = o_data_vld & ~i_wait;

  always_comb begin
    pc_d = pc_q;
    if (i_flush) begin
      pc_d = word_align(i_flush_addr);
    end else if (i_bpu_taken) begin
      pc_d = word_align(i_bpu_jaddr);
    end else if (grant) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (discard) begin
      drop_d = drop_d - 1'b1;
    end
    // Every allocated-unfilled entry still has a response on its way; the one
    // arriving now (if kept) is already accounted for.
    if (redirect) begin
      drop_d = drop_d + unfilled_cnt - CntW'(undiscard);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  ifu_fetch_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i          (i_clk),
    .rst_ni         (i_rstn),
    .clear_i        (redirect),
    .alloc_i        (grant),
    .alloc_addr_i   (ibus.addr),
    .fill_i         (fill),
    .fill_data_i    (ibus.rdata),
    .pop_i          (pop),
    .head_filled_o  (head_filled),
    .head_addr_o    (o_iaddr),
    .head_data_o    (o_data),
    .alloc_cnt_o    (alloc_cnt),
    .unfilled_cnt_o (unfilled_cnt)
  );

  rvld_has_owner: assert property (@(posedge i_clk) disable iff (!i_rstn)
    ibus.rvld |-> ((drop_q != '0) || (unfilled_cnt != '0)));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int unsigned QD     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_addr = '0;
  logic        i_bpu_taken = 1'b0;
  logic [31:0] i_bpu_jaddr = '0;
  logic        i_wait = 1'b0;
  logic        o_data_vld;
  logic [31:0] o_iaddr;
  logic [31:0] o_data;

  ifu_fetch_if ibus ();

  ifu_fetch #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_flush      (i_flush),
    .i_flush_addr (i_flush_addr),
    .i_bpu_taken  (i_bpu_taken),
    .i_bpu_jaddr  (i_bpu_jaddr),
    .i_wait       (i_wait),
    .ibus         (ibus),
    .o_data_vld   (o_data_vld),
    .o_iaddr      (o_iaddr),
    .o_data       (o_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    logic        wt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic        chk_iaddr;
    logic [31:0] exp_iaddr;
  } vec_t;

  rsp_t        pend[$];
  vec_t        vt[16];
  int          cyc;
  int          lat;
  int          pops;
  int          chk_cnt;
  int          pass_cnt;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Drive this cycle's response, then let combinational outputs settle.
  task automatic prep();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      ibus.rvld  = 1'b1;
      ibus.rdata = mem(pend[0].addr);
    end else begin
      ibus.rvld  = 1'b0;
      ibus.rdata = '0;
    end
    #1;
  endtask

  // Score the cycle, update the bus model and cross the clock edge.
  task automatic adv();
    bit          g;
    bit          r;
    logic [31:0] a;
    rsp_t        e;
    g = ibus.req & ibus.gnt;
    r = ibus.rvld;
    a = ibus.addr;
    if (pend.size() >= QD) check("credit_req", {31'b0, ibus.req}, 32'd0);
    if (o_data_vld && !i_wait) begin
      check("pop_iaddr", o_iaddr, exp_pc);
      check("pop_data", o_data, mem(o_iaddr));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (i_flush) exp_pc = i_flush_addr & 32'hFFFF_FFFC;
    else if (i_bpu_taken) exp_pc = i_bpu_jaddr & 32'hFFFF_FFFC;
    if (r) void'(pend.pop_front());
    if (g) begin
      e.addr = a;
      e.due  = cyc + lat;
      pend.push_back(e);
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    prep();
    adv();
  endtask

  task automatic do_reset();
    i_rstn      = 1'b0;
    i_flush     = 1'b0;
    i_bpu_taken = 1'b0;
    i_wait      = 1'b0;
    ibus.gnt    = 1'b0;
    ibus.rvld   = 1'b0;
    ibus.rdata  = '0;
    pend.delete();
    exp_pc = RST_PC;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    cyc    = 0;
  endtask

  task automatic wait_vld(input int max, input logic [31:0] want, input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < max && !seen; k++) begin
      prep();
      if (o_data_vld) begin
        seen = 1;
        check(nm, o_iaddr, want);
      end
      adv();
    end
    if (!seen) check({nm, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    pops     = 0;
    lat      = 1;
    cyc      = 0;
    exp_pc   = RST_PC;
    ibus.gnt   = 1'b0;
    ibus.rvld  = 1'b0;
    ibus.rdata = '0;

    //       wt  req  addr          vld  chk  iaddr
    vt[0]  = '{0, 1, 32'h00, 0, 0, 32'h00};
    vt[1]  = '{0, 1, 32'h04, 0, 0, 32'h00};
    vt[2]  = '{0, 0, 32'h08, 1, 1, 32'h00};
    vt[3]  = '{0, 1, 32'h08, 1, 1, 32'h04};
    vt[4]  = '{0, 1, 32'h0C, 0, 0, 32'h00};
    vt[5]  = '{0, 0, 32'h10, 1, 1, 32'h08};
    vt[6]  = '{0, 1, 32'h10, 1, 1, 32'h0C};
    vt[7]  = '{0, 1, 32'h14, 0, 0, 32'h00};
    vt[8]  = '{1, 0, 32'h18, 1, 1, 32'h10};
    vt[9]  = '{1, 0, 32'h18, 1, 1, 32'h10};
    vt[10] = '{1, 0, 32'h18, 1, 1, 32'h10};
    vt[11] = '{1, 0, 32'h18, 1, 1, 32'h10};
    vt[12] = '{1, 0, 32'h18, 1, 1, 32'h10};
    vt[13] = '{0, 0, 32'h18, 1, 1, 32'h10};
    vt[14] = '{0, 1, 32'h18, 1, 1, 32'h14};
    vt[15] = '{0, 1, 32'h1C, 0, 0, 32'h00};

    // Reset state
    #2;
    check("rst_req", {31'b0, ibus.req}, 32'd0);
    check("rst_vld", {31'b0, o_data_vld}, 32'd0);
    check("rst_iaddr", o_iaddr, 32'd0);
    check("rst_data", o_data, 32'd0);

    // Streaming at latency 1, then a 5-cycle stall holding 0x10
    do_reset();
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      i_wait   = vt[i].wt;
      ibus.gnt = 1'b1;
      prep();
      check($sformatf("vec%0d_req", i), {31'b0, ibus.req}, {31'b0, vt[i].exp_req});
      check($sformatf("vec%0d_addr", i), ibus.addr, vt[i].exp_addr);
      check($sformatf("vec%0d_vld", i), {31'b0, o_data_vld}, {31'b0, vt[i].exp_vld});
      if (vt[i].chk_iaddr) begin
        check($sformatf("vec%0d_iaddr", i), o_iaddr, vt[i].exp_iaddr);
        check($sformatf("vec%0d_data", i), o_data, mem(vt[i].exp_iaddr));
      end
      adv();
    end

    // Latency 3 with a gappy grant: credit limit and in-order delivery
    do_reset();
    lat  = 3;
    pops = 0;
    for (int k = 0; k < 60; k++) begin
      ibus.gnt = (k % 4 != 3);
      cycle();
    end
    check("lat3_progress", {31'b0, pops >= 10}, 32'd1);

    // Predicted-taken redirect with 0x20/0x24 in flight
    do_reset();
    lat      = 3;
    ibus.gnt = 1'b1;
    i_flush = 1'b1; i_flush_addr = 32'h20;
    cycle();
    i_flush = 1'b0;
    prep();
    check("bt_req0", ibus.addr, 32'h20);
    adv();
    prep();
    check("bt_req1", ibus.addr, 32'h24);
    adv();
    i_bpu_taken = 1'b1; i_bpu_jaddr = 32'h100;
    prep();
    check("bt_noreq", {31'b0, ibus.req}, 32'd0);
    adv();
    i_bpu_taken = 1'b0;
    prep();
    check("bt_addr_tgt", ibus.addr, 32'h100);
    check("bt_req_held", {31'b0, ibus.req}, 32'd0);
    check("bt_vld_drop", {31'b0, o_data_vld}, 32'd0);
    adv();
    prep();
    check("bt_req_tgt", {31'b0, ibus.req}, 32'd1);
    check("bt_vld_drop2", {31'b0, o_data_vld}, 32'd0);
    adv();
    wait_vld(20, 32'h100, "bt_first");

    // Flush and taken together while a live response arrives
    do_reset();
    lat      = 2;
    ibus.gnt = 1'b1;
    cycle();
    cycle();
    i_flush = 1'b1; i_flush_addr = 32'h200;
    i_bpu_taken = 1'b1; i_bpu_jaddr = 32'h300;
    prep();
    check("ft_vld", {31'b0, o_data_vld}, 32'd0);
    check("ft_noreq", {31'b0, ibus.req}, 32'd0);
    adv();
    i_flush = 1'b0; i_bpu_taken = 1'b0;
    prep();
    check("ft_req", {31'b0, ibus.req}, 32'd1);
    check("ft_addr", ibus.addr, 32'h200);
    adv();
    wait_vld(20, 32'h200, "ft_first");

    // Flush while a filled head is held: output must drop that cycle
    i_wait = 1'b1;
    repeat (4) cycle();
    prep();
    check("hold_vld", {31'b0, o_data_vld}, 32'd1);
    adv();
    i_flush = 1'b1; i_flush_addr = 32'h43;
    prep();
    check("flush_gates_vld", {31'b0, o_data_vld}, 32'd0);
    adv();
    i_flush = 1'b0; i_wait = 1'b0;
    wait_vld(20, 32'h40, "fl_first");

    // PC wrap-around from an unaligned target near the top of memory
    do_reset();
    lat      = 1;
    ibus.gnt = 1'b1;
    i_flush = 1'b1; i_flush_addr = 32'hFFFF_FFFB;
    cycle();
    i_flush = 1'b0;
    wait_vld(10, 32'hFFFF_FFF8, "wrap_first");
    pops = 0;
    repeat (8) cycle();
    check("wrap_progress", {31'b0, pops >= 3}, 32'd1);

    // Asynchronous reset with a full, stalled queue
    i_wait = 1'b1;
    repeat (6) cycle();
    prep();
    check("pre_rst_vld", {31'b0, o_data_vld}, 32'd1);
    i_rstn = 1'b0;
    #1;
    check("arst_req", {31'b0, ibus.req}, 32'd0);
    check("arst_vld", {31'b0, o_data_vld}, 32'd0);
    check("arst_iaddr", o_iaddr, 32'd0);
    check("arst_data", o_data, 32'd0);
    pend.delete();
    ibus.rvld = 1'b0;
    i_wait    = 1'b0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    cyc    = 0;
    exp_pc = RST_PC;
    prep();
    check("post_rst_req", {31'b0, ibus.req}, 32'd1);
    check("post_rst_addr", ibus.addr, RST_PC);
    adv();
    wait_vld(10, RST_PC, "post_rst_first");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
